// File: rtl/request_queue_pkg.sv
// Shared types and sizing for the request queue: parser opcodes, address width,
// queue depth/age defaults and the packed slot layout.
package request_queue_pkg;

    localparam int ADDRESS_WIDTH = 34;
    localparam int RQ_DEPTH      = 16;
    localparam int RQ_AGE_WIDTH  = 16;

    typedef enum logic [2:0] {
        NOP       = 3'd0,
        READ      = 3'd1,
        WRITE     = 3'd2,
        ACTIVATE  = 3'd3,
        PRECHARGE = 3'd4,
        REFRESH   = 3'd5
    } parsed_op_t;

    typedef struct packed {
        parsed_op_t                op;
        logic [ADDRESS_WIDTH-1:0]  addr;
        logic [RQ_AGE_WIDTH-1:0]   age;
    } rq_entry_t;

endpackage

// File: rtl/rq_entry.sv
// One queue slot: loads a request, clears on pop, and ages (saturating) while it
// holds a request. A slot is occupied exactly when its opcode is not NOP.
module rq_entry
    import request_queue_pkg::*;
#(
    parameter int AGE_WIDTH = RQ_AGE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      clear,
    input  parsed_op_t                load_op,
    input  logic [ADDRESS_WIDTH-1:0]  load_addr,
    output parsed_op_t                op,
    output logic [ADDRESS_WIDTH-1:0]  addr,
    output logic [AGE_WIDTH-1:0]      age
);

    localparam logic [AGE_WIDTH-1:0] AGE_MAX = {AGE_WIDTH{1'b1}};

    // Slot storage; load wins over clear so a full-queue push+pop can reuse the head slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op   <= NOP;
            addr <= {ADDRESS_WIDTH{1'b0}};
            age  <= {AGE_WIDTH{1'b0}};
        end else if (load) begin
            op   <= load_op;
            addr <= load_addr;
            age  <= {AGE_WIDTH{1'b0}};
        end else if (clear) begin
            op   <= NOP;
            addr <= {ADDRESS_WIDTH{1'b0}};
            age  <= {AGE_WIDTH{1'b0}};
        end else if ((op != NOP) && (age != AGE_MAX)) begin
            age  <= age + AGE_WIDTH'(1);
        end else begin
            age  <= age;
        end
    end

endmodule

// File: rtl/request_queue.sv
// In-order circular request queue between the trace parser and the DRAM command
// scheduler, exposing the head entry, its age, occupancy and overflow.
module request_queue
    import request_queue_pkg::*;
#(
    parameter int DEPTH     = RQ_DEPTH,
    parameter int AGE_WIDTH = RQ_AGE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      op_ready_s,
    input  parsed_op_t                opcode,
    input  logic [ADDRESS_WIDTH-1:0]  address,
    output logic                      out_valid,
    input  logic                      out_ready,
    output parsed_op_t                out_opcode,
    output logic [ADDRESS_WIDTH-1:0]  out_address,
    output logic [AGE_WIDTH-1:0]      out_age,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]          head_ptr_r;
    logic [PTR_W-1:0]          tail_ptr_r;
    logic                      push_s;
    logic                      pop_s;
    logic                      push_acc_s;
    logic                      reject_s;
    parsed_op_t                slot_op_s   [DEPTH];
    logic [ADDRESS_WIDTH-1:0]  slot_addr_s [DEPTH];
    logic [AGE_WIDTH-1:0]      slot_age_s  [DEPTH];

    // Handshake decode; a full queue still accepts a push when the head leaves this cycle.
    always_comb begin
        push_s     = op_ready_s && (opcode != NOP);
        pop_s      = (count != {CNT_W{1'b0}}) && out_ready;
        push_acc_s = push_s && ((count < FULL_CNT) || pop_s);
        reject_s   = push_s && !push_acc_s;
    end

    // Pointers, occupancy and the overflow pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_ptr_r <= {PTR_W{1'b0}};
            tail_ptr_r <= {PTR_W{1'b0}};
            count      <= {CNT_W{1'b0}};
            overflow   <= 1'b0;
        end else begin
            head_ptr_r <= pop_s      ? head_ptr_r + PTR_W'(1) : head_ptr_r;
            tail_ptr_r <= push_acc_s ? tail_ptr_r + PTR_W'(1) : tail_ptr_r;
            overflow   <= reject_s;
            case ({push_acc_s, pop_s})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        rq_entry #(
            .AGE_WIDTH (AGE_WIDTH)
        ) u_entry (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (push_acc_s && (tail_ptr_r == PTR_W'(g))),
            .clear     (pop_s && (head_ptr_r == PTR_W'(g))),
            .load_op   (opcode),
            .load_addr (address),
            .op        (slot_op_s[g]),
            .addr      (slot_addr_s[g]),
            .age       (slot_age_s[g])
        );
    end

    // Head view; vacated slots hold NOP/zero, so an empty queue reads back as zeros.
    always_comb begin
        out_opcode  = slot_op_s[head_ptr_r];
        out_address = slot_addr_s[head_ptr_r];
        out_age     = slot_age_s[head_ptr_r];
        empty       = (count == {CNT_W{1'b0}});
        full        = (count == FULL_CNT);
        out_valid   = !empty;
    end

endmodule

// File: tb/tb_request_queue.sv
// Self-checking bench for request_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model (two age widths).
module tb_request_queue;
    import request_queue_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic                     op_ready_s;
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     out_ready;

    logic                     a_valid, a_full, a_empty, a_ovf;
    parsed_op_t               a_op;
    logic [ADDRESS_WIDTH-1:0] a_addr;
    logic [15:0]              a_age;
    logic [4:0]               a_count;

    logic                     b_valid, b_full, b_empty, b_ovf;
    parsed_op_t               b_op;
    logic [ADDRESS_WIDTH-1:0] b_addr;
    logic [3:0]               b_age;
    logic [4:0]               b_count;

    request_queue #(.DEPTH(DEPTH), .AGE_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .op_ready_s(op_ready_s), .opcode(opcode), .address(address),
        .out_valid(a_valid), .out_ready(out_ready), .out_opcode(a_op), .out_address(a_addr),
        .out_age(a_age), .count(a_count), .full(a_full), .empty(a_empty), .overflow(a_ovf));

    request_queue #(.DEPTH(DEPTH), .AGE_WIDTH(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .op_ready_s(op_ready_s), .opcode(opcode), .address(address),
        .out_valid(b_valid), .out_ready(out_ready), .out_opcode(b_op), .out_address(b_addr),
        .out_age(b_age), .count(b_count), .full(b_full), .empty(b_empty), .overflow(b_ovf));

    typedef struct {
        parsed_op_t               op;
        logic [ADDRESS_WIDTH-1:0] addr;
        int                       born;
    } model_entry_t;

    model_entry_t model_q[$];
    int           edge_n = 0;
    logic         exp_ovf = 1'b0;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic int sat_age(input int age, input int max_age);
        return (age > max_age) ? max_age : age;
    endfunction

    // Apply the queue rules to the model for the inputs present at this edge,
    // clock the DUTs, then compare every observable output.
    task automatic step();
        model_entry_t e;
        int           sz;
        bit           push;
        bit           pop;
        edge_n++;
        if (!rst_n) begin
            model_q.delete();
            exp_ovf = 1'b0;
        end else begin
            push    = op_ready_s && (opcode != NOP);
            pop     = (model_q.size() > 0) && out_ready;
            exp_ovf = push && (model_q.size() == DEPTH) && !pop;
            if (pop) void'(model_q.pop_front());
            if (push && !exp_ovf) begin
                e.op = opcode; e.addr = address; e.born = edge_n;
                model_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        sz = model_q.size();
        check_eq("count",     64'(a_count), 64'(sz));
        check_eq("out_valid", 64'(a_valid), 64'(sz != 0));
        check_eq("empty",     64'(a_empty), 64'(sz == 0));
        check_eq("full",      64'(a_full),  64'(sz == DEPTH));
        check_eq("overflow",  64'(a_ovf),   64'(exp_ovf));
        check_eq("sat_count", 64'(b_count), 64'(sz));
        if (sz != 0) begin
            check_eq("out_opcode",  64'(a_op),   64'(model_q[0].op));
            check_eq("out_address", 64'(a_addr), 64'(model_q[0].addr));
            check_eq("out_age",     64'(a_age),  64'(sat_age(edge_n - model_q[0].born, 65535)));
            check_eq("sat_age",     64'(b_age),  64'(sat_age(edge_n - model_q[0].born, 15)));
        end else begin
            check_eq("out_opcode",  64'(a_op),   64'(NOP));
            check_eq("out_address", 64'(a_addr), 64'd0);
            check_eq("out_age",     64'(a_age),  64'd0);
            check_eq("sat_age",     64'(b_age),  64'd0);
        end
        op_ready_s = 1'b0;
    endtask

    task automatic push_op(input parsed_op_t op, input logic [ADDRESS_WIDTH-1:0] addr,
                           input logic rdy);
        op_ready_s = 1'b1;
        opcode     = op;
        address    = addr;
        out_ready  = rdy;
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        op_ready_s = 1'b0;
        opcode     = NOP;
        address    = {ADDRESS_WIDTH{1'b0}};
        out_ready  = 1'b0;
        step();
        step();

        // Idle after reset
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Single request, ageing, then pop
        push_op(READ, 34'h1_0000_0040, 1'b0);
        check_eq("t2_addr", 64'(a_addr), 64'h1_0000_0040);
        for (int i = 0; i < 5; i++) step();
        check_eq("t2_age5", 64'(a_age), 64'd5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        check_eq("t2_empty", 64'(a_empty), 64'd1);

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) push_op((i % 2 == 0) ? READ : WRITE, 34'(i), 1'b0);
        check_eq("t3_full", 64'(a_full), 64'd1);
        push_op(WRITE, 34'd16, 1'b0);
        check_eq("t3_ovf", 64'(a_ovf), 64'd1);
        step();
        check_eq("t3_ovf_pulse", 64'(a_ovf), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) step();
        out_ready = 1'b0;

        // Full queue with simultaneous push and pop, then wrap-around
        for (int i = 0; i < 16; i++) push_op(ACTIVATE, 34'(i), 1'b0);
        push_op(READ, 34'h0AA, 1'b1);
        check_eq("t4_count", 64'(a_count), 64'd16);
        check_eq("t4_head1", 64'(a_addr), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) step();
        out_ready = 1'b0;
        step();
        check_eq("t4_head_aa", 64'(a_addr), 64'h0AA);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset during push and pop
        for (int i = 0; i < 3; i++) push_op(WRITE, 34'(100 + i), 1'b0);
        rst_n = 1'b0;
        push_op(READ, 34'h3FF, 1'b1);
        rst_n = 1'b1;
        out_ready = 1'b0;
        check_eq("t5_count", 64'(a_count), 64'd0);
        step();

        // NOP strobe ignored; age saturation on the narrow instance
        push_op(NOP, 34'h123, 1'b0);
        check_eq("t6_nop_count", 64'(a_count), 64'd0);
        push_op(PRECHARGE, 34'h55, 1'b0);
        for (int i = 0; i < 20; i++) step();
        check_eq("t6_sat15", 64'(b_age), 64'd15);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            op_ready_s = ($urandom_range(0, 99) < 55);
            opcode     = parsed_op_t'(3'($urandom_range(0, 5)));
            address    = {2'($urandom), 32'($urandom)};
            out_ready  = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 70));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
